acq_controller: RTL and testbench

Acquisition sequencer for the DSO capture path. Arms on request, fills a programmable pre-trigger window into the circular sample buffer, then waits for the edge flag from the trigger comparator. It completes the post-trigger fill and reports the buffer start address for readout. It sits between the trigger comparator output, the sample buffer write port and the host/readout control logic.

---
 rtl/acq_controller_if.sv | 40 ++++
 rtl/acq_controller.sv | 122 ++++++++++++
 tb/tb_acq_controller.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/acq_controller_if.sv
// Control and buffer-write bundle for acq_controller.
// AUTO_TRIG_EN adds the auto_en / trig_auto pair.
interface acq_controller_if #(
    parameter int ADDR_W = 10
);
    logic              sample_en;
    logic              trig_in;
    logic              arm;
    logic              abort;
    logic              force_trig;
    logic [ADDR_W-1:0] pretrig;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] trig_addr;
    logic              busy;
    logic              done;
`ifdef AUTO_TRIG_EN
    logic              auto_en;
    logic              trig_auto;
`endif

    modport master (
`ifdef AUTO_TRIG_EN
        output auto_en,
        input  trig_auto,
`endif
        output sample_en, trig_in, arm, abort, force_trig, pretrig,
        input  wr_en, wr_addr, start_addr, trig_addr, busy, done
    );

    modport slave (
`ifdef AUTO_TRIG_EN
        input  auto_en,
        output trig_auto,
`endif
        input  sample_en, trig_in, arm, abort, force_trig, pretrig,
        output wr_en, wr_addr, start_addr, trig_addr, busy, done
    );
endinterface

// File: rtl/acq_controller.sv
// DSO acquisition sequencer: pre-trigger fill, trigger wait, post-trigger fill.
// Optional auto-trigger timeout is enabled with the AUTO_TRIG_EN macro.
module acq_controller #(
    parameter int ADDR_W       = 10
`ifdef AUTO_TRIG_EN
   ,parameter int AUTO_TIMEOUT = 4096
`endif
) (
    input logic              clk,
    input logic              rst_n,
    acq_controller_if.slave  bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRE       = 3'd1;
    localparam logic [2:0] WAIT_TRIG = 3'd2;
    localparam logic [2:0] POST      = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [ADDR_W-1:0] pre_r;
    logic [ADDR_W-1:0] post_r;
    logic [ADDR_W-1:0] trig_addr;
    logic              busy;
    logic              trig_hit;
    logic              take;

`ifdef AUTO_TRIG_EN
    localparam int              AUTO_W    = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);
    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_hit;
    logic              trig_auto;

    assign auto_hit      = bus.sample_en & bus.auto_en & (auto_cnt == AUTO_LAST);
    assign take          = trig_hit | auto_hit;
    assign bus.trig_auto = trig_auto;
`else
    assign take          = trig_hit;
`endif

    assign busy     = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
    assign trig_hit = bus.sample_en & (bus.trig_in | bus.force_trig);
    assign cnt_nxt  = cnt + 1'b1;

    assign bus.busy       = busy;
    assign bus.done       = (state == DONE);
    assign bus.wr_en      = bus.sample_en & busy;
    assign bus.wr_addr    = wr_addr;
    assign bus.trig_addr  = trig_addr;
    assign bus.start_addr = trig_addr - pre_r;

    // NOTE: all state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_addr   <= '0;
            cnt       <= '0;
            pre_r     <= '0;
            post_r    <= '0;
            trig_addr <= '0;
`ifdef AUTO_TRIG_EN
            auto_cnt  <= '0;
            trig_auto <= 1'b0;
`endif
        end else if (bus.abort) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.arm) begin
                        wr_addr <= '0;
                        cnt     <= '0;
                        pre_r   <= bus.pretrig;
                        // DEPTH-1 is all ones, so DEPTH-1-pretrig is a bitwise invert.
                        post_r  <= ~bus.pretrig;
                        state   <= (bus.pretrig == '0) ? WAIT_TRIG : PRE;
`ifdef AUTO_TRIG_EN
                        auto_cnt  <= '0;
                        trig_auto <= 1'b0;
`endif
                    end
                end
                PRE: begin
                    if (bus.sample_en) begin
                        wr_addr <= wr_addr + 1'b1;
                        cnt     <= cnt_nxt;
                        if (cnt_nxt == pre_r) state <= WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (bus.sample_en) begin
                        wr_addr <= wr_addr + 1'b1;
                        if (take) begin
                            trig_addr <= wr_addr;
                            cnt       <= '0;
                            state     <= (post_r == '0) ? DONE : POST;
`ifdef AUTO_TRIG_EN
                            trig_auto <= ~trig_hit;
`endif
                        end
`ifdef AUTO_TRIG_EN
                        // Saturate so a late auto_en fires on the next strobe.
                        if (!take && auto_cnt != AUTO_LAST) auto_cnt <= auto_cnt + 1'b1;
`endif
                    end
                end
                POST: begin
                    if (bus.sample_en) begin
                        wr_addr <= wr_addr + 1'b1;
                        cnt     <= cnt_nxt;
                        if (cnt_nxt == post_r) state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acq_controller.sv
// Directed testbench for acq_controller with ADDR_W=4 (DEPTH=16).
// Define AUTO_TRIG_EN to also exercise the auto-trigger path (AUTO_TIMEOUT=20).
module tb_acq_controller;
    localparam int ADDR_W = 4;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    acq_controller_if #(.ADDR_W(ADDR_W)) bus ();

`ifdef AUTO_TRIG_EN
    acq_controller #(.ADDR_W(ADDR_W), .AUTO_TIMEOUT(20)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    acq_controller #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1-2 time units after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic arm_with(input logic [ADDR_W-1:0] p);
        bus.pretrig = p;
        bus.arm     = 1'b1;
        tick();
        bus.arm     = 1'b0;
    endtask

    task automatic test_reset;
        bus.sample_en = 1'b1;
        rst_n = 1'b0;
        tick();
        #1;
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0b exp=0", bus.wr_en); end
        total++; if (bus.wr_addr !== 4'd0) begin bad++; $display("FAIL reset_wr_addr got=%0d exp=0", bus.wr_addr); end
        total++; if (bus.trig_addr !== 4'd0) begin bad++; $display("FAIL reset_trig_addr got=%0d exp=0", bus.trig_addr); end
        total++; if (bus.start_addr !== 4'd0) begin bad++; $display("FAIL reset_start_addr got=%0d exp=0", bus.start_addr); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
`ifdef AUTO_TRIG_EN
        total++; if (bus.trig_auto !== 1'b0) begin bad++; $display("FAIL reset_trig_auto got=%0b exp=0", bus.trig_auto); end
`endif
        rst_n = 1'b1;
        bus.sample_en = 1'b0;
        tick();
    endtask

    // pretrig=5, continuous strobes, trigger on the 9th WAIT sample (addr 13).
    task automatic test_basic;
        logic [ADDR_W-1:0] exp_addr;
        bus.sample_en = 1'b1;
        arm_with(4'd5);
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0b exp=1", bus.busy); end
        for (int i = 0; i < 24; i++) begin
            exp_addr    = 4'(i);
            bus.trig_in = (i == 13);
            #1;
            total++; if (bus.wr_en !== 1'b1) begin bad++; $display("FAIL basic_wr_en i=%0d got=%0b exp=1", i, bus.wr_en); end
            total++; if (bus.wr_addr !== exp_addr) begin bad++; $display("FAIL basic_wr_addr i=%0d got=%0d exp=%0d", i, bus.wr_addr, exp_addr); end
            if (i == 23) begin
                total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL basic_early_done got=%0b exp=0", bus.done); end
            end
            tick();
        end
        bus.trig_in = 1'b0;
        #1;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL basic_done got=%0b exp=1", bus.done); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%0b exp=0", bus.busy); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL basic_wr_en_done got=%0b exp=0", bus.wr_en); end
        total++; if (bus.trig_addr !== 4'd13) begin bad++; $display("FAIL basic_trig_addr got=%0d exp=13", bus.trig_addr); end
        total++; if (bus.start_addr !== 4'd8) begin bad++; $display("FAIL basic_start_addr got=%0d exp=8", bus.start_addr); end
        tick();
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL basic_done_hold got=%0b exp=1", bus.done); end
    endtask

    // Re-arm from DONE with pretrig=0, then pretrig=15 (no POST writes).
    task automatic test_boundaries;
        logic [ADDR_W-1:0] exp_addr;
        bus.sample_en = 1'b1;
        arm_with(4'd0);
        for (int i = 0; i < 16; i++) begin
            exp_addr    = 4'(i);
            bus.trig_in = (i == 0);
            #1;
            total++; if (bus.wr_addr !== exp_addr || bus.wr_en !== 1'b1) begin bad++; $display("FAIL pre0_write i=%0d got=%0d/%0b exp=%0d/1", i, bus.wr_addr, bus.wr_en, exp_addr); end
            tick();
        end
        bus.trig_in = 1'b0;
        #1;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL pre0_done got=%0b exp=1", bus.done); end
        total++; if (bus.trig_addr !== 4'd0) begin bad++; $display("FAIL pre0_trig_addr got=%0d exp=0", bus.trig_addr); end
        total++; if (bus.start_addr !== 4'd0) begin bad++; $display("FAIL pre0_start_addr got=%0d exp=0", bus.start_addr); end

        arm_with(4'd15);
        for (int i = 0; i < 16; i++) begin
            exp_addr    = 4'(i);
            bus.trig_in = (i == 15);
            #1;
            total++; if (bus.wr_addr !== exp_addr || bus.wr_en !== 1'b1) begin bad++; $display("FAIL pre15_write i=%0d got=%0d/%0b exp=%0d/1", i, bus.wr_addr, bus.wr_en, exp_addr); end
            tick();
        end
        bus.trig_in = 1'b0;
        #1;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL pre15_done got=%0b exp=1", bus.done); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL pre15_wr_en got=%0b exp=0", bus.wr_en); end
        total++; if (bus.trig_addr !== 4'd15) begin bad++; $display("FAIL pre15_trig_addr got=%0d exp=15", bus.trig_addr); end
        total++; if (bus.start_addr !== 4'd0) begin bad++; $display("FAIL pre15_start_addr got=%0d exp=0", bus.start_addr); end
    endtask

    // Strobe every 3rd cycle; trig_in at k=7 (no strobe) ignored, k=12 (strobe, addr 4) taken.
    task automatic test_decimated;
        logic [ADDR_W-1:0] exp_addr;
        logic              strobe;
        exp_addr = '0;
        arm_with(4'd2);
        for (int k = 0; k < 52; k++) begin
            strobe        = (k % 3 == 0);
            bus.sample_en = strobe;
            bus.trig_in   = (k == 7) || (k == 12);
            #1;
            total++; if (bus.wr_en !== strobe) begin bad++; $display("FAIL dec_wr_en k=%0d got=%0b exp=%0b", k, bus.wr_en, strobe); end
            total++; if (bus.wr_addr !== exp_addr) begin bad++; $display("FAIL dec_wr_addr k=%0d got=%0d exp=%0d", k, bus.wr_addr, exp_addr); end
            if (k == 51) begin
                total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL dec_early_done got=%0b exp=0", bus.done); end
            end
            if (strobe) exp_addr = exp_addr + 1'b1;
            tick();
        end
        bus.sample_en = 1'b0;
        bus.trig_in   = 1'b0;
        #1;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL dec_done got=%0b exp=1", bus.done); end
        total++; if (bus.trig_addr !== 4'd4) begin bad++; $display("FAIL dec_trig_addr got=%0d exp=4", bus.trig_addr); end
        total++; if (bus.start_addr !== 4'd2) begin bad++; $display("FAIL dec_start_addr got=%0d exp=2", bus.start_addr); end
    endtask

    // abort with arm in POST wins; a later arm restarts at address 0.
    task automatic test_abort;
        bus.sample_en = 1'b1;
        arm_with(4'd3);
        for (int i = 0; i < 6; i++) begin
            bus.trig_in = (i == 3);
            bus.abort   = (i == 5);
            bus.arm     = (i == 5);
            tick();
        end
        bus.trig_in = 1'b0;
        bus.abort   = 1'b0;
        bus.arm     = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%0b exp=0", bus.done); end
        total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL abort_wr_en got=%0b exp=0", bus.wr_en); end
        total++; if (bus.trig_addr !== 4'd3) begin bad++; $display("FAIL abort_trig_addr got=%0d exp=3", bus.trig_addr); end
        tick();
        arm_with(4'd3);
        #1;
        total++; if (bus.wr_addr !== 4'd0) begin bad++; $display("FAIL rearm_wr_addr got=%0d exp=0", bus.wr_addr); end
        total++; if (bus.busy !== 1'b1 || bus.wr_en !== 1'b1) begin bad++; $display("FAIL rearm_busy got=%0b/%0b exp=1/1", bus.busy, bus.wr_en); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    // rst_n low while in WAIT_TRIG, then a full capture with pretrig=4, trigger at addr 6.
    task automatic test_reset_mid;
        logic [ADDR_W-1:0] exp_addr;
        bus.sample_en = 1'b1;
        arm_with(4'd2);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        #1;
        total++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'd0) begin bad++; $display("FAIL midrst_write got=%0b/%0d exp=0/0", bus.wr_en, bus.wr_addr); end
        total++; if (bus.trig_addr !== 4'd0 || bus.start_addr !== 4'd0) begin bad++; $display("FAIL midrst_addr got=%0d/%0d exp=0/0", bus.trig_addr, bus.start_addr); end
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin bad++; $display("FAIL midrst_status got=%0b/%0b exp=0/0", bus.busy, bus.done); end
        rst_n = 1'b1;
        tick();
        arm_with(4'd4);
        for (int i = 0; i < 18; i++) begin
            exp_addr    = 4'(i);
            bus.trig_in = (i == 6);
            #1;
            total++; if (bus.wr_addr !== exp_addr || bus.wr_en !== 1'b1) begin bad++; $display("FAIL midrst_cap i=%0d got=%0d/%0b exp=%0d/1", i, bus.wr_addr, bus.wr_en, exp_addr); end
            tick();
        end
        bus.trig_in = 1'b0;
        #1;
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL midrst_done got=%0b exp=1", bus.done); end
        total++; if (bus.trig_addr !== 4'd6 || bus.start_addr !== 4'd2) begin bad++; $display("FAIL midrst_result got=%0d/%0d exp=6/2", bus.trig_addr, bus.start_addr); end
    endtask

`ifdef AUTO_TRIG_EN
    // pretrig=1: addr 0 in PRE, 20th WAIT strobe is addr 4, 14 POST writes.
    task automatic test_auto;
        logic [ADDR_W-1:0] exp_addr;
        bus.sample_en = 1'b1;
        bus.auto_en   = 1'b1;
        arm_with(4'd1);
        for (int i = 0; i < 35; i++) begin
            exp_addr = 4'(i);
            #1;
            total++; if (bus.wr_addr !== exp_addr) begin bad++; $display("FAIL auto_wr_addr i=%0d got=%0d exp=%0d", i, bus.wr_addr, exp_addr); end
            tick();
        end
        #1;
        total++; if (bus.done !== 1'b1 || bus.trig_auto !== 1'b1) begin bad++; $display("FAIL auto_done got=%0b/%0b exp=1/1", bus.done, bus.trig_auto); end
        total++; if (bus.trig_addr !== 4'd4 || bus.start_addr !== 4'd3) begin bad++; $display("FAIL auto_result got=%0d/%0d exp=4/3", bus.trig_addr, bus.start_addr); end
        bus.auto_en = 1'b0;
        arm_with(4'd1);
        repeat (40) tick();
        #1;
        total++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin bad++; $display("FAIL auto_off_wait got=%0b/%0b exp=1/0", bus.busy, bus.done); end
        total++; if (bus.trig_auto !== 1'b0) begin bad++; $display("FAIL auto_off_flag got=%0b exp=0", bus.trig_auto); end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        rst_n          = 1'b0;
        bus.sample_en  = 1'b0;
        bus.trig_in    = 1'b0;
        bus.arm        = 1'b0;
        bus.abort      = 1'b0;
        bus.force_trig = 1'b0;
        bus.pretrig    = '0;
`ifdef AUTO_TRIG_EN
        bus.auto_en    = 1'b0;
`endif
        tick();
        test_reset();
        test_basic();
        test_boundaries();
        test_decimated();
        test_abort();
        test_reset_mid();
`ifdef AUTO_TRIG_EN
        test_auto();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
